// File: rtl/tm_vector_sequencer.sv
// Replays up to DEPTH stored vectors into a netlist at a programmable issue rate and captures its outputs.
// Optional MISR compaction of captured outputs is enabled by defining TM_SEQ_MISR_EN.
module tm_vector_sequencer #(
    parameter int VEC_W   = 62,
    parameter int DEPTH   = 1000,
    parameter int ADDR_W  = 10,
    parameter int GAP_W   = 12,
    parameter int OUT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [VEC_W-1:0]  cfg_wdata,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [GAP_W-1:0]  gap,
    input  logic              start,
    input  logic              abort,
    output logic [VEC_W-1:0]  dut_in,
    output logic              dut_vld,
    input  logic [VEC_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   vec_cnt,
    output logic [31:0]       sig
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_DRV   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [VEC_W-1:0]  mem_r [DEPTH];
    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] idx_r, idx_nxt_s, last_r, last_nxt_s;
    logic [GAP_W-1:0]  gap_r, gap_nxt_s, gcnt_r, gcnt_nxt_s;
    logic [ADDR_W:0]   vec_cnt_r, vec_cnt_nxt_s;
    logic [VEC_W-1:0]  dut_in_r, dut_in_nxt_s;
    logic              dut_vld_r, dut_vld_nxt_s;
    logic              done_r, done_nxt_s, err_r, err_nxt_s, busy_r;
    logic [OUT_LAT-1:0] dly_r, dly_nxt_s;
    logic              cap_s, launch_s;

    // Config write port; writes are dropped while a run is in progress
    always_ff @(posedge clk) begin
        if (rst && cfg_we && (state_r == S_IDLE) && ({1'b0, cfg_addr} < DEPTH_L)) begin
            mem_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        last_nxt_s    = last_r;
        gap_nxt_s     = gap_r;
        gcnt_nxt_s    = gcnt_r;
        vec_cnt_nxt_s = vec_cnt_r;
        dut_in_nxt_s  = dut_in_r;
        dut_vld_nxt_s = 1'b0;
        done_nxt_s    = 1'b0;
        err_nxt_s     = 1'b0;
        launch_s      = 1'b0;
        // Delay line shifts the issue strobe; its top bit marks a capture cycle
        dly_nxt_s     = OUT_LAT'({dly_r, dut_vld_r});
        cap_s         = dly_r[OUT_LAT-1];
        if ((state_r != S_IDLE) && abort) begin
            state_nxt_s = S_IDLE;
            dly_nxt_s   = {OUT_LAT{1'b0}};
            cap_s       = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        if ({1'b0, last_idx} >= DEPTH_L) begin
                            err_nxt_s = 1'b1;
                        end else begin
                            launch_s      = 1'b1;
                            last_nxt_s    = last_idx;
                            gap_nxt_s     = gap;
                            idx_nxt_s     = {ADDR_W{1'b0}};
                            vec_cnt_nxt_s = {(ADDR_W+1){1'b0}};
                            state_nxt_s   = S_RD;
                        end
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_RD: begin
                    dut_in_nxt_s  = mem_r[idx_r];
                    dut_vld_nxt_s = 1'b1;
                    state_nxt_s   = S_DRV;
                end
                S_DRV: begin
                    vec_cnt_nxt_s = vec_cnt_r + (ADDR_W+1)'(1);
                    if (gap_r != {GAP_W{1'b0}}) begin
                        gcnt_nxt_s  = gap_r;
                        state_nxt_s = S_GAP;
                    end else if (idx_r < last_r) begin
                        idx_nxt_s   = idx_r + ADDR_W'(1);
                        state_nxt_s = S_RD;
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end
                S_GAP: begin
                    if (gcnt_r > GAP_W'(1)) begin
                        gcnt_nxt_s = gcnt_r - GAP_W'(1);
                    end else if (idx_r < last_r) begin
                        idx_nxt_s   = idx_r + ADDR_W'(1);
                        state_nxt_s = S_RD;
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dly_nxt_s == {OUT_LAT{1'b0}}) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            idx_r     <= {ADDR_W{1'b0}};
            last_r    <= {ADDR_W{1'b0}};
            gap_r     <= {GAP_W{1'b0}};
            gcnt_r    <= {GAP_W{1'b0}};
            vec_cnt_r <= {(ADDR_W+1){1'b0}};
            dut_in_r  <= {VEC_W{1'b0}};
            dut_vld_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            dly_r     <= {OUT_LAT{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            last_r    <= last_nxt_s;
            gap_r     <= gap_nxt_s;
            gcnt_r    <= gcnt_nxt_s;
            vec_cnt_r <= vec_cnt_nxt_s;
            dut_in_r  <= dut_in_nxt_s;
            dut_vld_r <= dut_vld_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            busy_r    <= (state_nxt_s != S_IDLE);
            dly_r     <= dly_nxt_s;
        end
    end

    assign dut_in  = dut_in_r;
    assign dut_vld = dut_vld_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign vec_cnt = vec_cnt_r;

`ifdef TM_SEQ_MISR_EN
    localparam int NSLICE = (VEC_W + 31) / 32;

    function automatic logic [31:0] fold32(input logic [VEC_W-1:0] v);
        logic [NSLICE*32-1:0] ext;
        logic [31:0]          acc;
        ext             = {(NSLICE*32){1'b0}};
        ext[VEC_W-1:0]  = v;
        acc             = 32'h0000_0000;
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ ext[i*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [VEC_W-1:0] v);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0000_0000) ^ fold32(v);
    endfunction

    logic [31:0] sig_r;

    // Signature register: seeded at run launch, advanced on each capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_r <= 32'hFFFF_FFFF;
        end else if (launch_s) begin
            sig_r <= 32'hFFFF_FFFF;
        end else if (cap_s) begin
            sig_r <= misr_step(sig_r, dut_out);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;
`else
    logic unused_capture_s;
    assign unused_capture_s = ^{dut_out, cap_s, launch_s};
    assign sig = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_tm_vector_sequencer.sv
// Directed self-checking bench for tm_vector_sequencer; outputs are looped back to inputs.
module tb_tm_vector_sequencer;
    localparam int VEC_W  = 62;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int GAP_W  = 12;
    localparam int LAT    = 2;
`ifdef TM_SEQ_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif
    localparam logic [31:0] SIG_RST = MISR_ON ? 32'hFFFF_FFFF : 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst, cfg_we, start, abort;
    logic [ADDR_W-1:0] cfg_addr, last_idx;
    logic [VEC_W-1:0]  cfg_wdata, dut_in, dut_out;
    logic [GAP_W-1:0]  gap;
    logic              dut_vld, busy, done, err;
    logic [ADDR_W:0]   vec_cnt;
    logic [31:0]       sig;

    int n_cmp = 0;
    int n_bad = 0;
    logic [VEC_W-1:0] model_mem [0:15];
    logic [31:0]      sig_model;

    always #5 clk = ~clk;
    assign dut_out = dut_in;

    tm_vector_sequencer #(
        .VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_W(GAP_W), .OUT_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .last_idx(last_idx), .gap(gap), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_vld(dut_vld), .dut_out(dut_out),
        .busy(busy), .done(done), .err(err), .vec_cnt(vec_cnt), .sig(sig)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [VEC_W-1:0] v);
        logic [31:0] f;
        f = v[31:0] ^ {2'b00, v[61:32]};
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0000_0000) ^ f;
    endfunction

    task automatic wr(input int a, input logic [VEC_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_din"}, 64'(dut_in), 64'(0));
        check({tag, "_vld"}, 64'(dut_vld), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_vcnt"}, 64'(vec_cnt), 64'(0));
        check({tag, "_sig"}, 64'(sig), 64'(SIG_RST));
    endtask

    // Plays vectors 0..last with the given gap; abort_at>0 raises abort in that cycle after start.
    task automatic play(input int last, input int g, input int abort_at);
        int n, per, last_vld, done_at, end_at, k, issued;
        logic exp_vld;
        logic [VEC_W-1:0] cur;
        n        = last + 1;
        per      = g + 2;
        last_vld = 2 + (n - 1) * per;
        // done follows the final capture, but never before DRAIN is entered after the trailing gap
        done_at  = (LAT > g + 1) ? last_vld + LAT + 1 : last_vld + g + 2;
        end_at   = (abort_at > 0) ? abort_at + 1 : done_at;
        sig_model = 32'hFFFF_FFFF;
        issued   = 0;
        last_idx = ADDR_W'(last); gap = GAP_W'(g); start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < end_at; c++) begin
            k = (c >= 2) ? (c - 2) / per : 0;
            if (k > n - 1) k = n - 1;
            cur = model_mem[k];
            exp_vld = (c >= 2) && ((c - 2) % per == 0) && (c <= last_vld);
            check("run_busy", 64'(busy), 64'(1));
            check("run_vld", 64'(dut_vld), 64'(exp_vld));
            check("run_done", 64'(done), 64'(0));
            if (c >= 2) check("run_din", 64'(dut_in), 64'(cur));
            if ((c - LAT >= 2) && ((c - LAT - 2) % per == 0) && (c - LAT <= last_vld) &&
                ((abort_at == 0) || (c < abort_at)))
                sig_model = misr_model(sig_model, cur);
            if (exp_vld) issued++;
            if (c == abort_at) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check("end_busy", 64'(busy), 64'(0));
        check("end_done", 64'(done), 64'(abort_at == 0));
        check("end_vcnt", 64'(vec_cnt), 64'(issued));
        check("end_din", 64'(dut_in), 64'(model_mem[issued - 1]));
        check("end_sig", 64'(sig), 64'(MISR_ON ? sig_model : 32'h0000_0000));
        tick();
        check("post_done", 64'(done), 64'(0));
        check("post_vld", 64'(dut_vld), 64'(0));
        check("post_busy", 64'(busy), 64'(0));
        check("post_din", 64'(dut_in), 64'(model_mem[issued - 1]));
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        last_idx = '0; gap = '0; start = 1'b0; abort = 1'b0;
        tick(); tick(); tick();
        check_reset_values("rst");
        rst = 1'b1;
        tick();

        wr(0, 62'h1);
        wr(1, 62'h2);
        wr(2, 62'h3);
        wr(3, 62'h3FFF_FFFF_FFFF_FFFF);
        for (int i = 4; i < 10; i++) wr(i, 62'(i) * 62'h0001_0203_0405_0607);

        // gap 0: issue every 2 cycles
        play(3, 0, 0);
        // gap 5: issue every 7 cycles
        play(3, 5, 0);

        // out-of-range last_idx is rejected
        last_idx = 10'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", 64'(err), 64'(1));
        check("err_busy", 64'(busy), 64'(0));
        check("err_vld", 64'(dut_vld), 64'(0));
        tick();
        check("err_clear", 64'(err), 64'(0));
        check("err_busy2", 64'(busy), 64'(0));
        check("err_vld2", 64'(dut_vld), 64'(0));

        // start with abort in idle: nothing starts
        last_idx = 10'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 64'(busy), 64'(0));
        check("sa_err", 64'(err), 64'(0));
        tick();
        check("sa_vld", 64'(dut_vld), 64'(0));
        check("sa_busy2", 64'(busy), 64'(0));

        // abort 3 cycles after second strobe of a 10-vector run
        play(9, 5, 12);

        // config write during a run is dropped, then reset mid-run
        last_idx = 10'd3; gap = 12'd0; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 10'd0; cfg_wdata = 62'h2A2A;
        tick();
        cfg_we = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_reset_values("midrst");
        rst = 1'b1;
        tick();
        play(3, 0, 0);

        // two-vector loopback signature
        play(1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
